// File: rtl/cr_write_sequencer_if.sv
// Bundle between the CR write sequencer and its environment:
// requesters, register file and paging unit. slave = sequencer.
interface cr_write_sequencer_if;
  logic        pf_req;
  logic [31:0] pf_linear_addr;
  logic        pf_ack;
  logic        ts_req;
  logic [31:0] ts_cr3;
  logic        ts_ack;
  logic        mov_req;
  logic [2:0]  mov_index;
  logic [31:0] mov_data;
  logic        mov_ack;
  logic        mov_fault;
  logic [31:0] cr0_current;
  logic [31:0] cr3_current;
  logic        cr_write_enable;
  logic [2:0]  cr_write_index;
  logic [31:0] cr_write_data;
  logic        tlb_flush_req;
  logic        tlb_flush_ack;
  logic        flush_timeout;
  logic        busy;

  modport master (
    output pf_req, pf_linear_addr,
    output ts_req, ts_cr3,
    output mov_req, mov_index, mov_data,
    output cr0_current, cr3_current,
    output tlb_flush_ack,
    input  pf_ack, ts_ack, mov_ack, mov_fault,
    input  cr_write_enable, cr_write_index,
    input  cr_write_data,
    input  tlb_flush_req, flush_timeout, busy
  );

  modport slave (
    input  pf_req, pf_linear_addr,
    input  ts_req, ts_cr3,
    input  mov_req, mov_index, mov_data,
    input  cr0_current, cr3_current,
    input  tlb_flush_ack,
    output pf_ack, ts_ack, mov_ack, mov_fault,
    output cr_write_enable, cr_write_index,
    output cr_write_data,
    output tlb_flush_req, flush_timeout, busy
  );
endinterface

// File: rtl/cr_write_sequencer.sv
// cr_write_sequencer: single write port into CR0..CR7; arbitrates
// pf (CR2) > ts (CR3) > mov (any CRn) and sequences the TLB flush.
// Ports: clock, reset_n (async, active low), bus (slave modport).
// Optional macro CR_WRITE_MASK_EN: rejects mov to CR1/CR4..7,
// clears CR3[11:0] and CR0[30:5] on accepted writes.
// All outputs are registered, decoded from the next state.
module cr_write_sequencer #(
  parameter logic [2:0] CR2_INDEX     = 3'd2,
  parameter logic [2:0] CR3_INDEX     = 3'd3,
  parameter int         FLUSH_TIMEOUT = 255
) (
  input logic           clock,
  input logic           reset_n,
  cr_write_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST =
    8'(FLUSH_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  win_q, win_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic        flush_q, flush_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tmo_d;

  logic        we_q, we_d;
  logic [2:0]  ack_q, ack_d;
  logic [2:0]  widx_q, widx_d;
  logic [31:0] wdata_q, wdata_d;
  logic        freq_q, freq_d;
  logic        tmo_q;
  logic        busy_q, busy_d;

`ifdef CR_WRITE_MASK_EN
  logic        rej_q, rej_d;
  logic        fault_q, fault_d;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      freq_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CR_WRITE_MASK_EN
      rej_q   <= 1'b0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      freq_q  <= freq_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
`ifdef CR_WRITE_MASK_EN
      rej_q   <= rej_d;
      fault_q <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wr_d    = wr_q;
    flush_d = flush_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`ifdef CR_WRITE_MASK_EN
    rej_d   = rej_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.pf_req | bus.ts_req | bus.mov_req) begin
          state_d = GRANT;
          wr_d    = 1'b1;
          flush_d = 1'b0;
`ifdef CR_WRITE_MASK_EN
          rej_d   = 1'b0;
`endif
          unique case (1'b1)
            bus.pf_req: begin
              win_d  = 3'b001;
              idx_d  = CR2_INDEX;
              data_d = bus.pf_linear_addr;
            end
            (!bus.pf_req && bus.ts_req): begin
              win_d   = 3'b010;
              idx_d   = CR3_INDEX;
              data_d  = bus.ts_cr3;
              flush_d = bus.ts_cr3[31:12] !=
                        bus.cr3_current[31:12];
`ifdef CR_WRITE_MASK_EN
              data_d[11:0] = 12'h0;
`endif
            end
            default: begin
              win_d   = 3'b100;
              idx_d   = bus.mov_index;
              data_d  = bus.mov_data;
              flush_d = (bus.mov_index == CR3_INDEX) ||
                        ((bus.mov_index == 3'd0) &&
                         (bus.mov_data[31] !=
                          bus.cr0_current[31]));
`ifdef CR_WRITE_MASK_EN
              if (bus.mov_index == 3'd1 ||
                  bus.mov_index[2]) begin
                wr_d    = 1'b0;
                rej_d   = 1'b1;
                flush_d = 1'b0;
              end else if (bus.mov_index ==
                           CR3_INDEX) begin
                data_d[11:0] = 12'h0;
              end else if (bus.mov_index ==
                           3'd0) begin
                data_d[30:5] = 26'h0;
              end
`endif
            end
          endcase
        end
      end
      GRANT: begin
        state_d = flush_q ? FLUSH : IDLE;
        cnt_d   = '0;
      end
      FLUSH: begin
        if (bus.tlb_flush_ack) begin
          state_d = IDLE;
        end else if (FLUSH_TIMEOUT != 0 &&
                     cnt_q == TO_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = (state_d == GRANT) && wr_d;
    ack_d   = (state_d == GRANT) ? win_d : 3'b000;
    widx_d  = we_d ? idx_d : 3'd0;
    wdata_d = we_d ? data_d : 32'h0;
    freq_d  = (state_d == FLUSH);
    busy_d  = (state_d != IDLE);
`ifdef CR_WRITE_MASK_EN
    fault_d = (state_d == GRANT) && rej_d;
`endif
  end

  assign bus.pf_ack          = ack_q[0];
  assign bus.ts_ack          = ack_q[1];
  assign bus.mov_ack         = ack_q[2];
  assign bus.cr_write_enable = we_q;
  assign bus.cr_write_index  = widx_q;
  assign bus.cr_write_data   = wdata_q;
  assign bus.tlb_flush_req   = freq_q;
  assign bus.flush_timeout   = tmo_q;
  assign bus.busy            = busy_q;
`ifdef CR_WRITE_MASK_EN
  assign bus.mov_fault       = fault_q;
`else
  assign bus.mov_fault       = 1'b0;
`endif

endmodule

// File: tb/tb_cr_write_sequencer.sv
// Bench for cr_write_sequencer: transaction model + per-cycle
// monitor, directed requests, flush, timeout and reset cases.
module tb_cr_write_sequencer;

  logic clock;
  logic reset_n;

  cr_write_sequencer_if bus();

  cr_write_sequencer #(
    .CR2_INDEX    (3'd2),
    .CR3_INDEX    (3'd3),
    .FLUSH_TIMEOUT(255)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit [2:0]  who;
    bit        we;
    bit [2:0]  idx;
    bit [31:0] data;
    bit        flush;
    bit        fault;
  } exp_t;

  exp_t expq[$];
  int   pass_n;
  int   total_n;
  int   cyc;
  int   last_ack_cyc;
  int   mov_ack_cyc;
  int   flush_done_cyc;
  bit   mon_pend;
  bit   mon_flush;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    total_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s: got %h, expected %h",
                  name, act, req);
  endtask

  function automatic exp_t predict(
    input int kind, input logic [2:0] idx,
    input logic [31:0] d, input logic [31:0] cr0,
    input logic [31:0] cr3);
    exp_t e;
    e.fault = 1'b0;
    e.we    = 1'b1;
    e.flush = 1'b0;
    e.data  = d;
    e.idx   = idx;
    if (kind == 0) begin
      e.who = 3'b001;
      e.idx = 3'd2;
    end else if (kind == 1) begin
      e.who   = 3'b010;
      e.idx   = 3'd3;
      e.flush = (d[31:12] != cr3[31:12]);
`ifdef CR_WRITE_MASK_EN
      e.data[11:0] = 12'h0;
`endif
    end else begin
      e.who   = 3'b100;
      e.flush = (idx == 3'd3) ||
                (idx == 3'd0 && d[31] != cr0[31]);
`ifdef CR_WRITE_MASK_EN
      if (idx == 3'd1 || idx >= 3'd4) begin
        e.we    = 1'b0;
        e.fault = 1'b1;
        e.flush = 1'b0;
      end else if (idx == 3'd3) begin
        e.data[11:0] = 12'h0;
      end else if (idx == 3'd0) begin
        e.data[30:5] = 26'h0;
      end
`endif
    end
    return e;
  endfunction

  task automatic monitor_step();
    logic [2:0] acks;
    exp_t e;
    acks = {bus.mov_ack, bus.ts_ack, bus.pf_ack};
    if (acks != 3'b000) begin
      if (expq.size() == 0) begin
        check("unexpected_ack", 32'(acks), 32'h0);
      end else begin
        e = expq.pop_front();
        check("ack_who", 32'(acks), 32'(e.who));
        check("write_en", 32'(bus.cr_write_enable),
              32'(e.we));
        if (e.we) begin
          check("write_idx", 32'(bus.cr_write_index),
                32'(e.idx));
          check("write_data", bus.cr_write_data,
                e.data);
        end
        check("mov_fault", 32'(bus.mov_fault),
              32'(e.fault));
        check("busy_grant", 32'(bus.busy), 32'h1);
        check("ack_gap",
              32'(cyc - last_ack_cyc >= 2), 32'h1);
        mon_pend  = 1'b1;
        mon_flush = e.flush;
      end
      last_ack_cyc = cyc;
      if (bus.mov_ack) mov_ack_cyc = cyc;
    end else begin
      check("idle_write_en",
            32'(bus.cr_write_enable), 32'h0);
      check("idle_mov_fault",
            32'(bus.mov_fault), 32'h0);
      if (mon_pend) begin
        check("flush_after_grant",
              32'(bus.tlb_flush_req), 32'(mon_flush));
        if (!mon_flush)
          check("busy_after_grant",
                32'(bus.busy), 32'h0);
        mon_pend = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (reset_n) monitor_step();
      else mon_pend = 1'b0;
    end
  end

  task automatic req_wait(input int who,
                          output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clock);
      n++;
      if (who == 0 && bus.pf_ack)  got = 1'b1;
      if (who == 1 && bus.ts_ack)  got = 1'b1;
      if (who == 2 && bus.mov_ack) got = 1'b1;
    end
    check("ack_arrived", 32'(got), 32'h1);
    if (who == 0) bus.pf_req = 1'b0;
    else if (who == 1) bus.ts_req = 1'b0;
    else bus.mov_req = 1'b0;
  endtask

  task automatic flush_respond(input int delay);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clock);
      seen = bus.tlb_flush_req;
    end
    check("flush_req_seen", 32'(seen), 32'h1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      check("flush_req_held",
            32'(bus.tlb_flush_req), 32'h1);
    end
    bus.tlb_flush_ack = 1'b1;
    @(negedge clock);
    bus.tlb_flush_ack = 1'b0;
    check("flush_req_drop",
          32'(bus.tlb_flush_req), 32'h0);
    check("busy_after_flush", 32'(bus.busy), 32'h0);
    flush_done_cyc = cyc;
  endtask

  task automatic issue_pf(input logic [31:0] a);
    bus.pf_req = 1'b1;
    bus.pf_linear_addr = a;
    expq.push_back(predict(0, 3'd0, a,
      bus.cr0_current, bus.cr3_current));
  endtask

  task automatic issue_ts(input logic [31:0] d);
    bus.ts_req = 1'b1;
    bus.ts_cr3 = d;
    expq.push_back(predict(1, 3'd0, d,
      bus.cr0_current, bus.cr3_current));
  endtask

  task automatic issue_mov(input logic [2:0] i,
                           input logic [31:0] d);
    bus.mov_req   = 1'b1;
    bus.mov_index = i;
    bus.mov_data  = d;
    expq.push_back(predict(2, i, d,
      bus.cr0_current, bus.cr3_current));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;
    pass_n = 0;
    total_n = 0;
    cyc = 0;
    last_ack_cyc = -10;
    mov_ack_cyc = 0;
    flush_done_cyc = 0;
    mon_pend = 1'b0;
    mon_flush = 1'b0;
    reset_n = 1'b0;
    bus.pf_req = 1'b0;
    bus.pf_linear_addr = '0;
    bus.ts_req = 1'b0;
    bus.ts_cr3 = '0;
    bus.mov_req = 1'b0;
    bus.mov_index = '0;
    bus.mov_data = '0;
    bus.cr0_current = '0;
    bus.cr3_current = '0;
    bus.tlb_flush_ack = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_outputs",
      {19'h0, bus.pf_ack, bus.ts_ack, bus.mov_ack,
       bus.mov_fault, bus.cr_write_enable,
       bus.cr_write_index, bus.tlb_flush_req,
       bus.flush_timeout, bus.busy}, 32'h0);
    check("rst_data", bus.cr_write_data, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // pf write of the faulting address
    issue_pf(32'hDEAD_B000);
    req_wait(0, n);
    check("pf_latency_le2", 32'(n <= 2), 32'h1);
    check("pf_idx_lit", 32'(bus.cr_write_index), 32'd2);
    check("pf_data_lit", bus.cr_write_data,
          32'hDEAD_B000);
    @(negedge clock);
    check("pf_no_flush", 32'(bus.tlb_flush_req), 32'h0);

    // three simultaneous requesters
    bus.cr3_current = 32'h0001_2000;
    @(negedge clock);
    issue_pf(32'h0000_1000);
    issue_ts(32'h0005_5000);
    issue_mov(3'd2, 32'h1234_5678);
    fork
      req_wait(0, n);
      req_wait(1, n);
      req_wait(2, n);
      flush_respond(3);
    join
    check("mov_after_ts_flush",
          32'(mov_ack_cyc > flush_done_cyc), 32'h1);

    // unchanged CR3 page base via ts: no flush
    bus.cr3_current = 32'h0001_2FFF;
    @(negedge clock);
    e = predict(1, 3'd0, 32'h0001_2000,
                32'h0, 32'h0001_2FFF);
    check("model_ts_noflush", 32'(e.flush), 32'h0);
    issue_ts(32'h0001_2000);
    req_wait(1, n);
    check("ts_idx_lit", 32'(bus.cr_write_index), 32'd3);
    repeat (3) begin
      @(negedge clock);
      check("ts_no_flush",
            32'(bus.tlb_flush_req), 32'h0);
    end

    // same value via mov always flushes
    e = predict(2, 3'd3, 32'h0001_2000,
                32'h0, 32'h0001_2FFF);
    check("model_mov_cr3_flush", 32'(e.flush), 32'h1);
    issue_mov(3'd3, 32'h0001_2000);
    req_wait(2, n);
    flush_respond(3);

    // PG toggle, no flush ack: timeout
    bus.cr0_current = 32'h0000_0001;
    @(negedge clock);
    issue_mov(3'd0, 32'h8000_0001);
    req_wait(2, n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (bus.tlb_flush_req) n++;
      else break;
    end
    check("timeout_len", 32'(n), 32'd255);
    check("timeout_pulse",
          32'(bus.flush_timeout), 32'h1);
    check("timeout_busy", 32'(bus.busy), 32'h0);
    @(negedge clock);
    check("timeout_one_cycle",
          32'(bus.flush_timeout), 32'h0);
    issue_pf(32'h00AB_C000);
    req_wait(0, n);

    // PG unchanged: no flush
    @(negedge clock);
    issue_mov(3'd0, 32'h0000_0011);
    req_wait(2, n);
    @(negedge clock);
    check("pg_same_no_flush",
          32'(bus.tlb_flush_req), 32'h0);

    // reset during FLUSH, stale ack ignored
    @(negedge clock);
    issue_ts(32'h0009_9000);
    req_wait(1, n);
    @(negedge clock);
    check("pre_rst_flush", 32'(bus.tlb_flush_req),
          32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_flush_req", 32'(bus.tlb_flush_req),
          32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    bus.tlb_flush_ack = 1'b1;
    @(negedge clock);
    bus.tlb_flush_ack = 1'b0;
    repeat (2) begin
      check("stale_ack_busy", 32'(bus.busy), 32'h0);
      check("stale_ack_freq",
            32'(bus.tlb_flush_req), 32'h0);
      @(negedge clock);
    end

`ifdef CR_WRITE_MASK_EN
    issue_mov(3'd5, 32'hCAFE_0005);
    req_wait(2, n);
    check("mask_fault_lit", 32'(bus.mov_fault), 32'h1);
    check("mask_no_we",
          32'(bus.cr_write_enable), 32'h0);
    @(negedge clock);
    issue_mov(3'd3, 32'h0000_5ABC);
    req_wait(2, n);
    check("mask_cr3_lit", bus.cr_write_data,
          32'h0000_5000);
    flush_respond(2);
`else
    issue_mov(3'd5, 32'hCAFE_0005);
    req_wait(2, n);
    check("mov5_idx_lit", 32'(bus.cr_write_index),
          32'd5);
    check("mov5_data_lit", bus.cr_write_data,
          32'hCAFE_0005);
    check("mov5_fault_lit", 32'(bus.mov_fault), 32'h0);
`endif

    repeat (3) @(negedge clock);
    check("queue_drained", 32'(expq.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
